// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus between the M stage and data memory.
interface memory_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/memory_stage.sv
// MIPS M stage: E->M pipeline register, req/ack data-memory access FSM,
// byte-lane steering and load extension.
//
// state  | meaning
// IDLE   | no access pending; non-memory op (or bubble) in M
// ACCESS | request driven to data memory, waiting for ack; pipeline held
// DONE   | access finished (or misaligned op rejected); result valid
module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallM,
  input  logic        flushM,
  input  logic        jumpE,
  input  logic        RegWriteE,
  input  logic        MemReadE,
  input  logic        MemWriteE,
  input  logic [1:0]  MemSizeE,
  input  logic        MemSignedE,
  input  logic [3:0]  MemtoRegE,
  input  logic [4:0]  WriteRegE,
  input  logic [31:0] ALUMultOutE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCPlus8E,
  output logic        jumpM,
  output logic        RegWriteM,
  output logic [3:0]  MemtoRegM,
  output logic [4:0]  WriteRegM,
  output logic [31:0] ReadDataM,
  output logic [31:0] ALUMultOutM,
  output logic [31:0] PCPlus8M,
  output logic        memBusyM,
  output logic        alignErrM,
  memory_stage_if.master dmem
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, stateNext;
  logic        regWriteR, memReadR, memWriteR, memSignedR, misR;
  logic [1:0]  memSizeR;
  logic [31:0] writeDataR;
  logic        adv, memOpE, misE;
  logic [31:0] shiftedRd, loadData;
  logic [3:0]  beRaw;
  logic [31:0] wdataRaw;

  assign adv = !stallM && (state != ACCESS);

  always_comb begin
    memOpE = MemReadE | MemWriteE;
    case (MemSizeE)
      2'b01:   misE = ALUMultOutE[0];
      2'b10:   misE = 1'b0;
      default: misE = |ALUMultOutE[1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (state == ACCESS) begin
      if (dmem.dmem_ack) stateNext = DONE;
    end else if (adv) begin
      if (flushM || !memOpE) stateNext = IDLE;
      else if (misE)         stateNext = DONE;
      else                   stateNext = ACCESS;
    end
  end

  // Payload fields are not reset: they are only meaningful behind the enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      regWriteR <= 1'b0;
      memReadR  <= 1'b0;
      memWriteR <= 1'b0;
      jumpM     <= 1'b0;
      misR      <= 1'b0;
      alignErrM <= 1'b0;
    end else begin
      alignErrM <= 1'b0;
      if (adv) begin
        if (flushM) begin
          regWriteR <= 1'b0;
          memReadR  <= 1'b0;
          memWriteR <= 1'b0;
          jumpM     <= 1'b0;
          misR      <= 1'b0;
        end else begin
          regWriteR   <= RegWriteE;
          memReadR    <= MemReadE;
          memWriteR   <= MemWriteE;
          jumpM       <= jumpE;
          memSizeR    <= MemSizeE;
          memSignedR  <= MemSignedE;
          MemtoRegM   <= MemtoRegE;
          WriteRegM   <= WriteRegE;
          ALUMultOutM <= ALUMultOutE;
          writeDataR  <= WriteDataE;
          PCPlus8M    <= PCPlus8E;
          misR        <= memOpE && misE;
          alignErrM   <= memOpE && misE;
        end
      end
    end
  end

  assign shiftedRd = dmem.dmem_rdata >> {ALUMultOutM[1:0], 3'b000};

  always_comb begin
    case (memSizeR)
      2'b01:   loadData = {{16{memSignedR & shiftedRd[15]}}, shiftedRd[15:0]};
      2'b10:   loadData = {{24{memSignedR & shiftedRd[7]}}, shiftedRd[7:0]};
      default: loadData = dmem.dmem_rdata;
    endcase
  end

  // Ack is honoured even under stallM; only the M register is held.
  always_ff @(posedge clk) begin
    if (rst) ReadDataM <= 32'd0;
    else if (state == ACCESS && dmem.dmem_ack && memReadR) ReadDataM <= loadData;
  end

  always_comb begin
    case (memSizeR)
      2'b01: begin
        beRaw    = 4'b0011 << ALUMultOutM[1:0];
        wdataRaw = {2{writeDataR[15:0]}};
      end
      2'b10: begin
        beRaw    = 4'b0001 << ALUMultOutM[1:0];
        wdataRaw = {4{writeDataR[7:0]}};
      end
      default: begin
        beRaw    = 4'b1111;
        wdataRaw = writeDataR;
      end
    endcase
  end

  assign dmem.dmem_req   = (state == ACCESS);
  assign dmem.dmem_we    = dmem.dmem_req && memWriteR;
  assign dmem.dmem_be    = dmem.dmem_req ? beRaw : 4'b0000;
  assign dmem.dmem_addr  = {ALUMultOutM[31:2], 2'b00};
  assign dmem.dmem_wdata = wdataRaw;

  assign memBusyM  = (state == ACCESS);
  assign RegWriteM = regWriteR && (state != ACCESS) && !misR;

endmodule

// File: tb/tb_memory_stage.sv
// Directed and randomized checks of memory_stage against a byte-level model.
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        rst, stallM, flushM;
  logic        jumpE, RegWriteE, MemReadE, MemWriteE, MemSignedE;
  logic [1:0]  MemSizeE;
  logic [3:0]  MemtoRegE;
  logic [4:0]  WriteRegE;
  logic [31:0] ALUMultOutE, WriteDataE, PCPlus8E;
  logic        jumpM, RegWriteM, memBusyM, alignErrM;
  logic [3:0]  MemtoRegM;
  logic [4:0]  WriteRegM;
  logic [31:0] ReadDataM, ALUMultOutM, PCPlus8M;

  int          checkCnt = 0;
  int          passCnt  = 0;
  logic [31:0] expRd;

  memory_stage_if bus ();

  memory_stage dut (
    .clk(clk), .rst(rst), .stallM(stallM), .flushM(flushM),
    .jumpE(jumpE), .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
    .MemSizeE(MemSizeE), .MemSignedE(MemSignedE), .MemtoRegE(MemtoRegE),
    .WriteRegE(WriteRegE), .ALUMultOutE(ALUMultOutE), .WriteDataE(WriteDataE),
    .PCPlus8E(PCPlus8E), .jumpM(jumpM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .WriteRegM(WriteRegM), .ReadDataM(ReadDataM), .ALUMultOutM(ALUMultOutM),
    .PCPlus8M(PCPlus8M), .memBusyM(memBusyM), .alignErrM(alignErrM), .dmem(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setNop();
    jumpE = 1'b0; RegWriteE = 1'b0; MemReadE = 1'b0; MemWriteE = 1'b0;
    MemSizeE = 2'd0; MemSignedE = 1'b0; MemtoRegE = 4'd0; WriteRegE = 5'd0;
    ALUMultOutE = 32'd0; WriteDataE = 32'd0; PCPlus8E = 32'd0;
  endtask

  // Reference model: everything derived from access width in bytes.
  function automatic int nBytes(input logic [1:0] sz);
    if (sz == 2'd1) return 2;
    if (sz == 2'd2) return 1;
    return 4;
  endfunction

  function automatic bit isMis(input logic [1:0] sz, input logic [31:0] addr);
    return (int'(addr[1:0]) % nBytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] mBe(input logic [1:0] sz, input logic [31:0] addr);
    logic [3:0] be;
    int off = int'(addr[1:0]);
    for (int b = 0; b < 4; b++) be[b] = (b >= off) && (b < off + nBytes(sz));
    return be;
  endfunction

  function automatic logic [31:0] mWdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = wd[8*(b % nBytes(sz)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] mLoad(input logic [31:0] rd, input logic [1:0] sz,
                                        input logic [31:0] addr, input bit sgn);
    logic [31:0] v = 32'd0;
    int n = nBytes(sz);
    int off = int'(addr[1:0]);
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off + i) +: 8];
    if (sgn && v[8*n - 1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic memOp(input bit rd, input bit wr, input logic [1:0] sz, input bit sgn,
                       input bit rw, input logic [4:0] wreg, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rdata, input int delay,
                       input bit holdFlush);
    setNop();
    MemReadE = rd; MemWriteE = wr; MemSizeE = sz; MemSignedE = sgn;
    RegWriteE = rw; WriteRegE = wreg; ALUMultOutE = addr; WriteDataE = wd;
    MemtoRegE = {3'd0, rd}; PCPlus8E = addr + 32'd8;
    step();
    setNop();
    if (isMis(sz, addr)) begin
      chk("misAlignErr", 32'(alignErrM), 32'd1);
      chk("misReq", 32'(bus.dmem_req), 32'd0);
      chk("misRegWrite", 32'(RegWriteM), 32'd0);
      step();
      chk("misAlignErrClr", 32'(alignErrM), 32'd0);
      chk("misReqIdle", 32'(bus.dmem_req), 32'd0);
    end else begin
      flushM = holdFlush;
      for (int c = 1; c <= delay; c++) begin
        chk("accReq", 32'(bus.dmem_req), 32'd1);
        chk("accBusy", 32'(memBusyM), 32'd1);
        chk("accWe", 32'(bus.dmem_we), 32'(wr));
        chk("accBe", 32'(bus.dmem_be), 32'(mBe(sz, addr)));
        chk("accAddr", bus.dmem_addr, {addr[31:2], 2'b00});
        if (wr) chk("accWdata", bus.dmem_wdata, mWdata(sz, wd));
        chk("accRegWrite", 32'(RegWriteM), 32'd0);
        if (c == delay) begin
          bus.dmem_ack = 1'b1;
          bus.dmem_rdata = rdata;
        end
        step();
      end
      bus.dmem_ack = 1'b0;
      flushM = 1'b0;
      if (rd) expRd = mLoad(rdata, sz, addr, sgn);
      chk("doneBusy", 32'(memBusyM), 32'd0);
      chk("doneReq", 32'(bus.dmem_req), 32'd0);
      chk("doneReadData", ReadDataM, expRd);
      chk("doneRegWrite", 32'(RegWriteM), 32'(rw));
      chk("doneWriteReg", 32'(WriteRegM), 32'(wreg));
      step();
    end
  endtask

  initial begin
    int reqCnt;
    rst = 1'b1; stallM = 1'b0; flushM = 1'b0;
    setNop();
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;
    expRd = 32'd0;
    step(); step();
    chk("rstReq", 32'(bus.dmem_req), 32'd0);
    chk("rstBusy", 32'(memBusyM), 32'd0);
    chk("rstAlignErr", 32'(alignErrM), 32'd0);
    chk("rstReadData", ReadDataM, 32'd0);
    chk("rstRegWrite", 32'(RegWriteM), 32'd0);
    chk("rstJump", 32'(jumpM), 32'd0);
    rst = 1'b0;
    step();

    // lw with ack on the third ACCESS cycle
    memOp(1, 0, 2'd0, 0, 1, 5'd3, 32'h100, 32'd0, 32'hDEADBEEF, 3, 0);
    chk("lwData", ReadDataM, 32'hDEADBEEF);

    // lb / lbu from top byte lane, flush requested during the access
    memOp(1, 0, 2'd2, 1, 1, 5'd4, 32'h103, 32'd0, 32'h80112233, 2, 1);
    chk("lbSigned", ReadDataM, 32'hFFFFFF80);
    memOp(1, 0, 2'd2, 0, 1, 5'd4, 32'h103, 32'd0, 32'h80112233, 1, 0);
    chk("lbUnsigned", ReadDataM, 32'h00000080);

    // sh with stallM held five cycles: exactly one request
    setNop();
    MemWriteE = 1'b1; MemSizeE = 2'd1; ALUMultOutE = 32'h202; WriteDataE = 32'h0000ABCD;
    step();
    setNop();
    stallM = 1'b1;
    reqCnt = 0;
    chk("shWe", 32'(bus.dmem_we), 32'd1);
    chk("shBe", 32'(bus.dmem_be), 32'hC);
    chk("shWdata", bus.dmem_wdata, 32'hABCDABCD);
    chk("shAddr", bus.dmem_addr, 32'h200);
    if (bus.dmem_req) reqCnt++;
    bus.dmem_ack = 1'b1;
    step();
    bus.dmem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.dmem_req) reqCnt++;
      chk("shStallBusy", 32'(memBusyM), 32'd0);
      step();
    end
    stallM = 1'b0;
    chk("shReqCount", 32'(reqCnt), 32'd1);
    chk("shReadDataKept", ReadDataM, expRd);
    step();

    // misaligned lw
    memOp(1, 0, 2'd0, 0, 1, 5'd7, 32'h101, 32'd0, 32'd0, 1, 0);

    // ALU op, flushed then not
    setNop();
    RegWriteE = 1'b1; WriteRegE = 5'd9; ALUMultOutE = 32'h55; flushM = 1'b1;
    step();
    chk("aluFlushRegWrite", 32'(RegWriteM), 32'd0);
    flushM = 1'b0;
    step();
    chk("aluRegWrite", 32'(RegWriteM), 32'd1);
    chk("aluWriteReg", 32'(WriteRegM), 32'd9);
    chk("aluResult", ALUMultOutM, 32'h55);
    chk("aluNoReq", 32'(bus.dmem_req), 32'd0);
    setNop();
    step();

    // reset during ACCESS, then a late ack
    setNop();
    MemReadE = 1'b1; RegWriteE = 1'b1; ALUMultOutE = 32'h300;
    step();
    setNop();
    chk("rstAccReq", 32'(bus.dmem_req), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expRd = 32'd0;
    chk("rstAccReqDrop", 32'(bus.dmem_req), 32'd0);
    chk("rstAccBusy", 32'(memBusyM), 32'd0);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h12345678;
    step();
    bus.dmem_ack = 1'b0;
    chk("lateAckReadData", ReadDataM, 32'd0);
    chk("lateAckReq", 32'(bus.dmem_req), 32'd0);

    // randomized loads/stores of all sizes and offsets
    for (int k = 0; k < 60; k++) begin
      logic [1:0]  sz;
      logic [31:0] addr;
      bit          rd;
      sz   = 2'($urandom_range(0, 3));
      addr = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) addr[1:0] = 2'b00;
      rd   = 1'($urandom_range(0, 1));
      memOp(rd, !rd, sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), addr, $urandom, $urandom,
            $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
